// File: rtl/design_46.sv
// design_46: registered W-bit unsigned adder with a one-cycle valid strobe.
// Operands are captured on every rising clk edge where start is high, and the
// wrapped sum (carry-out discarded) appears on y in the following cycle with
// valid asserted for exactly that cycle.
//
// Build option:
//   DESIGN_46_Y_CLEAR_EN - when defined, y is cleared to zero on every edge
//                          where start is low, so y is nonzero only while
//                          valid is high. When undefined, y holds its last sum.
//   valid timing and the y value during valid cycles are the same either way.
module design_46 #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
    output logic         valid
);

    // Sum is taken at W bits so the carry-out falls away and the result wraps.
    logic [W-1:0] sum;
    logic [W-1:0] y_d;
    logic [W-1:0] y_q;
    logic         valid_d;
    logic         valid_q;

    assign sum = a + b;

    // Next-state selection for the result and strobe registers.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        y_d     = y_q;
        valid_d = start;
        if (start) begin
            y_d = sum;
        end else begin
`ifdef DESIGN_46_Y_CLEAR_EN
            y_d = '0;
`else
            y_d = y_q;
`endif
        end
    end

    // Result and strobe registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order. The
        // async reset also drops a pending valid, since valid_q is the only
        // place that pending strobe lives.
        if (!rst_n) begin
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    // Outputs come straight from flops: no combinational input-to-output path.
    assign y     = y_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_design_46.sv
// Self-checking bench for design_46 (W=10). Expected sums are pushed to a
// scoreboard queue when start is driven and popped when valid is observed.
module tb_design_46;

    localparam int W = 10;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         valid;

    logic [W-1:0] sb_q[$];
    logic         exp_valid;
    logic [W-1:0] model_y;
    logic [W-1:0] exp_sum;
    int           pass_cnt;
    int           total_cnt;

    design_46 #(.W(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .y    (y),
        .valid(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus at the falling edge, record the expectation,
    // then return just after the rising edge that samples it.
    task automatic step(input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb);
        logic [W-1:0] s_sum;
        @(negedge clk);
        start = s;
        a     = aa;
        b     = bb;
        s_sum = aa + bb;
        if (s) sb_q.push_back(s_sum);
        exp_valid = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        #2;
        total_cnt++;
        if (valid !== 1'b0 || y !== '0) $display("FAIL reset_async: valid=%b y=%0d, want valid=0 y=0", valid, y);
        else pass_cnt++;
        // start while reset is held must be ignored
        @(negedge clk);
        start = 1'b1;
        a = 10'd2;
        b = 10'd9;
        @(posedge clk);
        #1;
        total_cnt++;
        if (valid !== 1'b0 || y !== '0) $display("FAIL reset_ignore_start: valid=%b y=%0d, want valid=0 y=0", valid, y);
        else pass_cnt++;
        // release with start already high: the very first edge must capture
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (valid !== 1'b1 || y !== 10'd11) $display("FAIL reset_first_edge: valid=%b y=%0d, want valid=1 y=11", valid, y);
        else pass_cnt++;
        model_y = 10'd11;
        step(1'b0, '0, '0);
`ifdef DESIGN_46_Y_CLEAR_EN
        model_y = '0;
`endif
        total_cnt++;
        if (valid !== 1'b0 || y !== model_y) $display("FAIL reset_after_first: valid=%b y=%0d, want valid=0 y=%0d", valid, y, model_y);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        step(1'b1, 10'd3, 10'd4);
        exp_sum = sb_q.pop_front();
        model_y = exp_sum;
        total_cnt++;
        if (valid !== 1'b1 || y !== 10'd7) $display("FAIL basic_sum: valid=%b y=%0d, want valid=1 y=7", valid, y);
        else pass_cnt++;
        step(1'b0, 10'd3, 10'd4);
`ifdef DESIGN_46_Y_CLEAR_EN
        model_y = '0;
`endif
        total_cnt++;
        if (valid !== 1'b0 || y !== model_y) $display("FAIL basic_after: valid=%b y=%0d, want valid=0 y=%0d", valid, y, model_y);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        step(1'b1, 10'd1023, 10'd1);
        exp_sum = sb_q.pop_front();
        model_y = exp_sum;
        total_cnt++;
        if (valid !== 1'b1 || y !== 10'd0) $display("FAIL wrap_1023_1: valid=%b y=%0d, want valid=1 y=0", valid, y);
        else pass_cnt++;
        step(1'b1, 10'd1023, 10'd1023);
        exp_sum = sb_q.pop_front();
        model_y = exp_sum;
        total_cnt++;
        if (valid !== 1'b1 || y !== 10'd1022) $display("FAIL wrap_1023_1023: valid=%b y=%0d, want valid=1 y=1022", valid, y);
        else pass_cnt++;
        step(1'b0, '0, '0);
`ifdef DESIGN_46_Y_CLEAR_EN
        model_y = '0;
`endif
        total_cnt++;
        if (valid !== 1'b0 || y !== model_y) $display("FAIL wrap_after: valid=%b y=%0d, want valid=0 y=%0d", valid, y, model_y);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        step(1'b1, 10'd10, 10'd20);
        exp_sum = sb_q.pop_front();
        model_y = exp_sum;
        total_cnt++;
        if (valid !== 1'b1 || y !== 10'd30) $display("FAIL b2b_first: valid=%b y=%0d, want valid=1 y=30", valid, y);
        else pass_cnt++;
        step(1'b1, 10'd100, 10'd200);
        exp_sum = sb_q.pop_front();
        model_y = exp_sum;
        total_cnt++;
        if (valid !== 1'b1 || y !== 10'd300) $display("FAIL b2b_second: valid=%b y=%0d, want valid=1 y=300", valid, y);
        else pass_cnt++;
        step(1'b0, 10'd7, 10'd8);
`ifdef DESIGN_46_Y_CLEAR_EN
        model_y = '0;
`endif
        total_cnt++;
        if (valid !== 1'b0 || y !== model_y) $display("FAIL b2b_after: valid=%b y=%0d, want valid=0 y=%0d", valid, y, model_y);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        step(1'b1, 10'd5, 10'd6);
        exp_sum = sb_q.pop_front();
        total_cnt++;
        if (valid !== 1'b1 || y !== exp_sum) $display("FAIL mid_before_reset: valid=%b y=%0d, want valid=1 y=%0d", valid, y, exp_sum);
        else pass_cnt++;
        // drop reset between edges: outputs must clear without a clock edge
        #1;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        model_y = '0;
        total_cnt++;
        if (valid !== 1'b0 || y !== '0) $display("FAIL mid_async_clear: valid=%b y=%0d, want valid=0 y=0", valid, y);
        else pass_cnt++;
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 10'd5, 10'd6);
            total_cnt++;
            if (valid !== 1'b0 || y !== '0) $display("FAIL mid_no_spurious[%0d]: valid=%b y=%0d, want valid=0 y=0", i, valid, y);
            else pass_cnt++;
        end
    endtask

    task automatic test_idle();
        // load a known nonzero value first so holding is observable
        step(1'b1, 10'd400, 10'd212);
        exp_sum = sb_q.pop_front();
        model_y = exp_sum;
        total_cnt++;
        if (valid !== 1'b1 || y !== 10'd612) $display("FAIL idle_load: valid=%b y=%0d, want valid=1 y=612", valid, y);
        else pass_cnt++;
`ifdef DESIGN_46_Y_CLEAR_EN
        model_y = '0;
`endif
        for (int i = 0; i < 20; i++) begin
            step(1'b0, W'($urandom), W'($urandom));
            total_cnt++;
            if (valid !== 1'b0 || y !== model_y) $display("FAIL idle[%0d]: valid=%b y=%0d, want valid=0 y=%0d", i, valid, y, model_y);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, W'($urandom), W'($urandom));
            if (sb_q.size() == 0) begin
                total_cnt++;
                $display("FAIL rand_sb_empty[%0d]: queue size=0, want 1", i);
            end else begin
                exp_sum = sb_q.pop_front();
                model_y = exp_sum;
                total_cnt++;
                if (valid !== 1'b1 || y !== exp_sum) $display("FAIL rand_sum[%0d]: valid=%b y=%0d, want valid=1 y=%0d", i, valid, y, exp_sum);
                else pass_cnt++;
            end
`ifdef DESIGN_46_Y_CLEAR_EN
            model_y = '0;
`endif
            for (int j = 0; j < 3; j++) begin
                step(1'b0, W'($urandom), W'($urandom));
                total_cnt++;
                if (valid !== 1'b0 || y !== model_y) $display("FAIL rand_idle[%0d.%0d]: valid=%b y=%0d, want valid=0 y=%0d", i, j, valid, y, model_y);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (sb_q.size() != 0) $display("FAIL rand_sb_drain: queue size=%0d, want 0", sb_q.size());
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        exp_valid = 1'b0;
        model_y   = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_idle();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/design_46.md
DESIGN_46 -- requirements
Module: design_46

Interface
REQ-001 Parameter: W, default 10, operand and result width in bits; legal range W >= 1.
REQ-002 clk  input  1  rising-edge clock for all sequential logic.
REQ-003 rst_n  input  1  reset, asynchronous, active-low; clock clk.
REQ-004 start  input  1  request; sampled on each rising clk edge; a and b are captured when high.
REQ-005 a  input  W  first unsigned operand.
REQ-006 b  input  W  second unsigned operand.
REQ-007 y  output  W  registered sum result.
REQ-008 valid  output  1  result-valid strobe, registered.

Function
REQ-009 The block SHALL capture a and b on every rising clk edge where start=1 and rst_n=1, and SHALL register y <= (a + b) mod 2^W on that same edge.
REQ-010 The block SHALL assert valid=1 in the cycle immediately following each cycle in which start was sampled high, giving a fixed latency of exactly one clock.
REQ-011 valid SHALL be 0 in any cycle not immediately preceded by a sampled start=1; no handshake or back-pressure exists.
REQ-012 The adder carry-out SHALL be discarded, so the sum wraps modulo 2^W; no overflow flag is produced.
REQ-013 Back-to-back start: for start high in N consecutive cycles, valid SHALL stay high for N consecutive cycles, and y in each of those cycles SHALL equal the sum of the operands sampled one cycle earlier.
REQ-014 When start=0 and the clear feature is disabled, y SHALL hold its last value (see REQ-020).
REQ-015 Operand changes while start=0 SHALL have no effect on y or valid.
REQ-016 The block SHALL contain no combinational path from any input to y or valid.

Reset
REQ-017 While rst_n=0, valid SHALL be 0 and y SHALL be all-zeros, applied asynchronously and without waiting for a clk edge.
REQ-018 start is ignored while rst_n=0; if reset asserts after start was sampled but before valid appears, the pending valid SHALL be discarded.
REQ-019 On the first rising edge after rst_n deasserts, the block SHALL operate normally; a start sampled on that edge SHALL produce valid on the next cycle.

Configuration
REQ-020 Macro DESIGN_46_Y_CLEAR_EN: when defined, y SHALL be registered to zero on every edge where start=0, so y is nonzero only in valid cycles; when undefined, y SHALL hold its previous value when start=0. valid timing and the y value during valid SHALL be identical in both builds.

Verification
REQ-021 W=10: reset, then a=3, b=4, start one cycle -> next cycle valid=1, y=7; the following cycle valid=0.
REQ-022 Wrap: a=1023, b=1 -> valid=1, y=0; and a=1023, b=1023 -> y=1022.
REQ-023 Back-to-back: start high for 2 cycles with (10,20) then (100,200) -> valid high for 2 cycles with y=30, then y=300; valid low after.
REQ-024 Reset mid-operation: start sampled with a=5, b=6, then rst_n drops before the next edge -> valid=0 and y=0 immediately; after release, no spurious valid.
REQ-025 Idle: rst_n=1, start=0 for 20 cycles with random a and b -> valid stays 0; y holds its value (zero when DESIGN_46_Y_CLEAR_EN is defined).
REQ-026 Random: 10 pairs, start pulses separated by 3 idle cycles -> every valid cycle has y == (a+b) mod 1024 of the operands sampled one cycle before.
